// File: rtl/cpu_pkg.sv
// Shared CPU-slice types and default bus geometry, imported by the RAM, MAR and bus modules.
package cpu_pkg;

  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADDR_W = 4;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    PROG
  } ram_state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/bus_ram_if.sv
// Control/status bundle between the CPU sequencer / front panel and bus_ram.
// display_data exists only when BUS_RAM_DISPLAY_EN is defined.
interface bus_ram_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
);

  logic              read_from_bus;
  logic              write_to_bus;
  logic              manual_mode;
  logic              manual_write;
  logic              manual_addr_load;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] program_switches;
  logic [ADDR_W-1:0] prog_ptr;
  logic              busy;
  logic              bus_conflict;
`ifdef BUS_RAM_DISPLAY_EN
  logic [DATA_W-1:0] display_data;
`endif

  modport master (
    output read_from_bus, write_to_bus, manual_mode, manual_write, manual_addr_load,
    output address, program_switches,
    input  prog_ptr, busy, bus_conflict
`ifdef BUS_RAM_DISPLAY_EN
    , input display_data
`endif
  );

  modport slave (
    input  read_from_bus, write_to_bus, manual_mode, manual_write, manual_addr_load,
    input  address, program_switches,
    output prog_ptr, busy, bus_conflict
`ifdef BUS_RAM_DISPLAY_EN
    , output display_data
`endif
  );

endinterface

// File: rtl/rise_detect.sv
// One-bit rising-edge detector: rise = d & ~previous sample, combinational from d.
// History resets to 1 so a level already high when reset ends never reports an edge.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= 1'b1;
    end else begin
      prev <= d;
    end
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/bus_ram.sv
// Parametrised bus-attached RAM: post-reset clear sweep, zero-cycle bus read, manual programming.
// Optional registered front-panel readout when BUS_RAM_DISPLAY_EN is defined.
module bus_ram
  import cpu_pkg::*;
#(
  parameter int                DATA_W     = CPU_DATA_W,
  parameter int                ADDR_W     = CPU_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_ram_if.slave          ctl,
  inout  wire  [DATA_W-1:0] bus
);

  localparam int DEPTH = depth_of(ADDR_W);

  ram_state_t        state;
  ram_state_t        state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] prog_ptr_q;
  logic              busy_q;
  logic              conflict_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_rise;
  logic              ld_rise;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              bus_oe;
  logic              run_both;

  rise_detect u_wr_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ctl.manual_write),
    .rise (wr_rise)
  );

  rise_detect u_ld_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ctl.manual_addr_load),
    .rise (ld_rise)
  );

  assign run_both = ctl.read_from_bus & ctl.write_to_bus;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Single memory write port shared by the sweep, bus captures and manual commits.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_wa    = clr_ptr;
    mem_wd    = INIT_VALUE;
    bus_oe    = 1'b0;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        if (&clr_ptr) begin
          state_nxt = ctl.manual_mode ? PROG : RUN;
        end
      end
      RUN: begin
        if (ctl.read_from_bus && !ctl.write_to_bus) begin
          mem_we = 1'b1;
          mem_wa = ctl.address;
          mem_wd = bus;
        end
        bus_oe = ctl.write_to_bus && !ctl.read_from_bus;
        if (ctl.manual_mode) begin
          state_nxt = PROG;
        end
      end
      PROG: begin
        if (wr_rise) begin
          mem_we = 1'b1;
          mem_wa = prog_ptr_q;
          mem_wd = ctl.program_switches;
        end
        if (!ctl.manual_mode) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_ptr    <= '0;
      prog_ptr_q <= '0;
      busy_q     <= 1'b1;
      conflict_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt == CLEAR);
      if (state == CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
      if (state == RUN && run_both) begin
        conflict_q <= 1'b1;
      end
      // A load edge coinciding with a write edge overrides the post-write increment.
      if (state == PROG) begin
        if (wr_rise) begin
          prog_ptr_q <= prog_ptr_q + 1'b1;
        end
        if (ld_rise) begin
          prog_ptr_q <= ctl.address;
        end
      end
    end
  end

  // Contents survive reset; the sweep that follows does the clearing.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign bus = (bus_oe && rst_n) ? mem[ctl.address] : 'z;

  assign ctl.prog_ptr     = prog_ptr_q;
  assign ctl.busy         = busy_q;
  assign ctl.bus_conflict = conflict_q;

`ifdef BUS_RAM_DISPLAY_EN
  logic [DATA_W-1:0] disp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q <= '0;
    end else if (state == CLEAR) begin
      disp_q <= '0;
    end else if (state == PROG) begin
      disp_q <= mem[prog_ptr_q];
    end else begin
      disp_q <= mem[ctl.address];
    end
  end

  assign ctl.display_data = disp_q;
`endif

endmodule

// File: tb/tb_bus_ram.sv
// Directed-plus-random bench for bus_ram against an array/queue reference model.
// Display readout checks are compiled in when BUS_RAM_DISPLAY_EN is defined.
module tb_bus_ram;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_ram_if #(.DATA_W(DW), .ADDR_W(AW)) ctl ();

  wire  [DW-1:0] bus;
  logic          tb_drv = 1'b0;
  logic [DW-1:0] tb_dat = '0;
  assign bus = tb_drv ? tb_dat : 'z;

  // Reference for what an undriven net reads as in this simulator.
  logic          float_en = 1'b0;
  wire  [DW-1:0] float_net;
  assign float_net = float_en ? '0 : 'z;

  bus_ram #(.DATA_W(DW), .ADDR_W(AW), .INIT_VALUE('0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctl  (ctl),
    .bus  (bus)
  );

  int            vectors    = 0;
  int            miscompares = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  int            ref_ptr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_z(input string tag);
    vectors++;
    assert (bus === float_net) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=undriven", tag, bus);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_ptr = 0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (ctl.busy === 1'b1 && n < 64) begin
`ifdef BUS_RAM_DISPLAY_EN
      check({tag, "_disp"}, ctl.display_data, 0);
`endif
      n++;
      tick();
    end
    check(tag, n, DEPTH);
  endtask

  task automatic run_write(input int a, input logic [DW-1:0] d);
    ctl.address       = AW'(a);
    tb_dat            = d;
    tb_drv            = 1'b1;
    ctl.read_from_bus = 1'b1;
    tick();
    ctl.read_from_bus = 1'b0;
    tb_drv            = 1'b0;
    ref_mem[a]        = d;
  endtask

  task automatic run_read(input string tag, input int a);
    ctl.address      = AW'(a);
    ctl.write_to_bus = 1'b1;
    #1;
    check(tag, bus, ref_mem[a]);
    ctl.write_to_bus = 1'b0;
    #1;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) run_read(tag, i);
  endtask

  task automatic press_write(input logic [DW-1:0] d);
    ctl.program_switches = d;
    ctl.manual_write     = 1'b1;
    tick();
    ctl.manual_write     = 1'b0;
    tick();
    ref_mem[ref_ptr] = d;
    ref_ptr          = (ref_ptr + 1) % DEPTH;
  endtask

  task automatic press_load(input int a);
    ctl.address          = AW'(a);
    ctl.manual_addr_load = 1'b1;
    tick();
    ctl.manual_addr_load = 1'b0;
    tick();
    ref_ptr = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl.read_from_bus    = 1'b0;
    ctl.write_to_bus     = 1'b0;
    ctl.manual_mode      = 1'b1;
    ctl.manual_write     = 1'b0;
    ctl.manual_addr_load = 1'b0;
    ctl.address          = '0;
    ctl.program_switches = '0;

    // Power-up reset, sweep lands in PROG.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_busy", ctl.busy, 1);
    check("rst_ptr", ctl.prog_ptr, 0);
    check("rst_conflict", ctl.bus_conflict, 0);
    check_z("rst_bus");
    wait_clear("clear0_len");
    model_clear();

    // Preload every word, then prove the sweep wipes it.
    for (int i = 0; i < DEPTH; i++) press_write(DW'($urandom_range(1, 255)));
    check("preload_ptr_wrap", ctl.prog_ptr, ref_ptr);
    ctl.manual_mode = 1'b0;
    pulse_reset();
    check("rst2_busy", ctl.busy, 1);
    check("rst2_ptr", ctl.prog_ptr, 0);
    wait_clear("clear1_len");
    model_clear();
    read_all("cleared_word");

    // Run-mode write then zero-cycle read.
    run_write(3, 8'hA5);
    ctl.address      = 4'h3;
    ctl.write_to_bus = 1'b1;
    #1;
    check("run_read_a5", bus, 8'hA5);
    ctl.write_to_bus = 1'b0;
    #1;
    check_z("run_release_z");

    for (int i = 0; i < 24; i++) begin
      run_write($urandom_range(0, DEPTH - 1), DW'($urandom));
      run_read("run_rand", $urandom_range(0, DEPTH - 1));
    end

    // Contention: no drive, no capture, sticky flag.
    run_write(5, 8'h77);
    ctl.address       = 4'h5;
    ctl.read_from_bus = 1'b1;
    ctl.write_to_bus  = 1'b1;
    #1;
    check_z("conflict_bus_z");
    tick();
    check("conflict_set", ctl.bus_conflict, 1);
    tb_dat = 8'h12;
    tb_drv = 1'b1;
    tick();
    ctl.read_from_bus = 1'b0;
    ctl.write_to_bus  = 1'b0;
    tb_drv            = 1'b0;
    run_read("conflict_mem5", 5);
    repeat (5) tick();
    check("conflict_sticky", ctl.bus_conflict, 1);

    // Programming with pointer wrap and a held button.
    ctl.manual_mode = 1'b1;
    tick();
    press_load(14);
    check("prog_load_e", ctl.prog_ptr, ref_ptr);
    press_write(8'h11);
    press_write(8'h22);
    press_write(8'h33);
    check("prog_wrap_ptr", ctl.prog_ptr, 1);
    ctl.program_switches = 8'h44;
    ctl.manual_write     = 1'b1;
    repeat (10) tick();
    ctl.manual_write = 1'b0;
    tick();
    ref_mem[ref_ptr] = 8'h44;
    ref_ptr          = (ref_ptr + 1) % DEPTH;
    check("prog_held_once", ctl.prog_ptr, 2);

    // Simultaneous write and load edges: write at old pointer, load wins.
    ctl.address          = 4'h9;
    ctl.program_switches = 8'h5A;
    ctl.manual_write     = 1'b1;
    ctl.manual_addr_load = 1'b1;
    tick();
    ctl.manual_write     = 1'b0;
    ctl.manual_addr_load = 1'b0;
    tick();
    ref_mem[ref_ptr] = 8'h5A;
    ref_ptr          = 9;
    check("prog_both_edges", ctl.prog_ptr, ref_ptr);

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) press_load($urandom_range(0, DEPTH - 1));
      else press_write(DW'($urandom));
      check("prog_rand_ptr", ctl.prog_ptr, ref_ptr);
    end

    // Manual isolation from the bus.
    ctl.address      = 4'h2;
    ctl.write_to_bus = 1'b1;
    #1;
    check_z("prog_bus_z");
    ctl.write_to_bus  = 1'b0;
    ctl.address       = 4'h9;
    tb_dat            = ~ref_mem[9];
    tb_drv            = 1'b1;
    ctl.read_from_bus = 1'b1;
    tick();
    ctl.read_from_bus = 1'b0;
    tb_drv            = 1'b0;

`ifdef BUS_RAM_DISPLAY_EN
    press_load(2);
    press_write(8'h5C);
    ctl.address          = 4'h2;
    ctl.manual_addr_load = 1'b1;
    tick();
    ctl.manual_addr_load = 1'b0;
    ref_ptr              = 2;
    tick();
    check("disp_prog", ctl.display_data, 8'h5C);
`endif

    ctl.manual_mode = 1'b0;
    tick();
    check("run_ptr_kept", ctl.prog_ptr, ref_ptr);
    read_all("after_prog");

    // Reset mid-sweep with the write button held throughout.
    ctl.manual_mode  = 1'b1;
    ctl.manual_write = 1'b1;
    pulse_reset();
    check("rst3_conflict", ctl.bus_conflict, 0);
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_clear("midsweep_len");
    model_clear();
    repeat (3) tick();
    check("held_no_fire", ctl.prog_ptr, 0);
    ctl.manual_write = 1'b0;
    ctl.manual_mode  = 1'b0;
    tick();
    read_all("midsweep_word");
    check("final_conflict", ctl.bus_conflict, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
